// File: rtl/imem_controller_if.sv
// Instruction-memory port bundle between imem_controller and the memory.
// The controller drives every signal; the memory only observes them.
interface imem_controller_if ();

    logic        i_write;
    logic        i_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output i_write,
        output i_enable,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        input i_write,
        input i_enable,
        input mem_addr,
        input mem_wdata
    );

endinterface

// File: rtl/imem_controller.sv
// Sequencer and arbiter for the instruction-fetch stage.
// Owns the single instruction-memory port: in LOAD it writes the program
// image word by word starting at LOAD_BASE; in RUN it hands the port to the
// fetch address and releases halt. Out-of-image fetches stop the core with
// a sticky fault flag. All outputs are registered except the RUN-mode
// address, which follows pc_mem directly so fetches see no added latency.
module imem_controller #(
    parameter logic [31:0] LOAD_BASE = 32'd10000,
    parameter int          MAX_WORDS = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 program_load,
    input  logic                 start,
    input  logic                 load_valid,
    input  logic [31:0]          instruction,
    input  logic                 load_done,
    input  logic                 halt_req,
    input  logic [31:0]          pc_mem,
    output logic                 halt,
    imem_controller_if.master    mem,
    output logic                 pc_init,
    output logic [CNT_W-1:0]     load_count,
    output logic                 overflow,
    output logic                 fault,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_WORDS);

    state_t cur_state;
    state_t next_state;

    // Registered copies of the memory-port outputs.
    logic        i_write_q;
    logic        i_enable_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    // Next values for every registered output.
    logic             halt_n;
    logic             i_write_n;
    logic             i_enable_n;
    logic [31:0]      mem_addr_n;
    logic [31:0]      mem_wdata_n;
    logic             pc_init_n;
    logic [CNT_W-1:0] load_count_n;
    logic             overflow_n;
    logic             fault_n;

    // Byte address one past the last loaded word. It doubles as the
    // address of the next word to be written and as the end of the image.
    logic [31:0] count_bytes;
    logic [31:0] next_word_addr;
    logic        word_accept;
    logic        word_drop;
    logic        fetch_fault;
    logic        entering_load;

    assign count_bytes    = 32'(load_count) << 2;
    assign next_word_addr = LOAD_BASE + count_bytes;

    assign word_accept = (cur_state == LOAD) && load_valid && (load_count < MAX_COUNT);
    assign word_drop   = (cur_state == LOAD) && load_valid && !(load_count < MAX_COUNT);

    // The first RUN cycle is skipped because if_stage is still loading its
    // PC from LOAD_BASE and pc_mem does not yet reflect the new value.
    assign fetch_fault = (cur_state == RUN) && !pc_init &&
                         ((pc_mem < LOAD_BASE) ||
                          (pc_mem >= next_word_addr) ||
                          (pc_mem[1:0] != 2'b00));

    assign entering_load = (next_state == LOAD) && (cur_state != LOAD);

    // State register: the FSM is the only writer of the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state selection: program_load always outranks start.
    always_comb begin
        next_state = cur_state;
        unique case (cur_state)
            IDLE: begin
                if (program_load) begin
                    next_state = LOAD;
                end else if (start && (load_count != '0)) begin
                    next_state = RUN;
                end
            end
            LOAD: begin
                if (load_done) begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (halt_req || fetch_fault) begin
                    next_state = HALTED;
                end
            end
            HALTED: begin
                if (program_load) begin
                    next_state = LOAD;
                end else if (start) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output logic: compute what each registered output holds after the edge.
    always_comb begin
        halt_n       = 1'b1;
        i_write_n    = 1'b0;
        i_enable_n   = 1'b0;
        mem_addr_n   = mem_addr_q;
        mem_wdata_n  = mem_wdata_q;
        pc_init_n    = 1'b0;
        load_count_n = load_count;
        overflow_n   = overflow;
        fault_n      = fault;

        // A word accepted in LOAD is written one cycle later, even when
        // load_done arrives with it and the FSM is already back in IDLE.
        if (word_accept) begin
            i_write_n    = 1'b1;
            i_enable_n   = 1'b1;
            mem_addr_n   = next_word_addr;
            mem_wdata_n  = instruction;
            load_count_n = load_count + CNT_W'(1);
        end

        if (word_drop) begin
            overflow_n = 1'b1;
        end

        // Track the fetch address so it is held when RUN is left.
        if (cur_state == RUN) begin
            mem_addr_n = pc_mem;
        end

        if (fetch_fault) begin
            fault_n = 1'b1;
        end

        if (next_state == RUN) begin
            halt_n     = 1'b0;
            i_enable_n = 1'b1;
            pc_init_n  = (cur_state == IDLE);
            if (cur_state == HALTED) begin
                fault_n = 1'b0;
            end
        end

        if (entering_load) begin
            load_count_n = '0;
            overflow_n   = 1'b0;
            fault_n      = 1'b0;
        end
    end

    // Output registers with synchronous reset to the quiescent, halted state.
    always_ff @(posedge clk) begin
        if (reset) begin
            halt        <= 1'b1;
            i_write_q   <= 1'b0;
            i_enable_q  <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            pc_init     <= 1'b0;
            load_count  <= '0;
            overflow    <= 1'b0;
            fault       <= 1'b0;
        end else begin
            halt        <= halt_n;
            i_write_q   <= i_write_n;
            i_enable_q  <= i_enable_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            pc_init     <= pc_init_n;
            load_count  <= load_count_n;
            overflow    <= overflow_n;
            fault       <= fault_n;
        end
    end

    assign mem.i_write   = i_write_q;
    assign mem.i_enable  = i_enable_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_addr  = (cur_state == RUN) ? pc_mem : mem_addr_q;
    assign state         = cur_state;

endmodule

// File: tb/tb_imem_controller.sv
// Directed self-checking bench for imem_controller (built with MAX_WORDS=4).
module tb_imem_controller;

    logic        clk;
    logic        reset;
    logic        program_load;
    logic        start;
    logic        load_valid;
    logic [31:0] instruction;
    logic        load_done;
    logic        halt_req;
    logic [31:0] pc_mem;
    logic        halt;
    logic        pc_init;
    logic [15:0] load_count;
    logic        overflow;
    logic        fault;
    logic [1:0]  state;

    int errors;
    int checks;

    imem_controller_if mem_bus ();

    imem_controller #(
        .LOAD_BASE (32'd10000),
        .MAX_WORDS (4),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .program_load (program_load),
        .start        (start),
        .load_valid   (load_valid),
        .instruction  (instruction),
        .load_done    (load_done),
        .halt_req     (halt_req),
        .pc_mem       (pc_mem),
        .halt         (halt),
        .mem          (mem_bus.master),
        .pc_init      (pc_init),
        .load_count   (load_count),
        .overflow     (overflow),
        .fault        (fault),
        .state        (state)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the run never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL reset_halt: got %b expected 1", halt); end
        checks++; if (mem_bus.i_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_i_write: got %b expected 0", mem_bus.i_write); end
        checks++; if (mem_bus.i_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_i_enable: got %b expected 0", mem_bus.i_enable); end
        checks++; if (mem_bus.mem_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %0d expected 0", mem_bus.mem_addr); end
        checks++; if (mem_bus.mem_wdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", mem_bus.mem_wdata); end
        checks++; if (pc_init !== 1'b0) begin errors++; $display("[TB] FAIL reset_pc_init: got %b expected 0", pc_init); end
        checks++; if (load_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_load_count: got %0d expected 0", load_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
        reset = 1'b0;
    endtask

    task automatic test_start_ignored_when_empty();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL empty_start_state: got %0d expected 0", state); end
        checks++; if (pc_init !== 1'b0) begin errors++; $display("[TB] FAIL empty_start_pc_init: got %b expected 0", pc_init); end
    endtask

    task automatic test_load();
        logic [31:0] words [3];
        words[0] = 32'h20080005;
        words[1] = 32'h20090007;
        words[2] = 32'h01095020;
        program_load = 1'b1;
        tick();
        program_load = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL load_enter_state: got %0d expected 1", state); end
        checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL load_halt: got %b expected 1", halt); end
        for (int i = 0; i < 3; i++) begin
            load_valid  = 1'b1;
            instruction = words[i];
            tick();
            checks++; if (mem_bus.i_write !== 1'b1) begin errors++; $display("[TB] FAIL load_i_write[%0d]: got %b expected 1", i, mem_bus.i_write); end
            checks++; if (mem_bus.i_enable !== 1'b1) begin errors++; $display("[TB] FAIL load_i_enable[%0d]: got %b expected 1", i, mem_bus.i_enable); end
            checks++; if (mem_bus.mem_addr !== 32'd10000 + 32'(4 * i)) begin errors++; $display("[TB] FAIL load_addr[%0d]: got %0d expected %0d", i, mem_bus.mem_addr, 10000 + 4 * i); end
            checks++; if (mem_bus.mem_wdata !== words[i]) begin errors++; $display("[TB] FAIL load_wdata[%0d]: got %h expected %h", i, mem_bus.mem_wdata, words[i]); end
            checks++; if (load_count !== 16'(i + 1)) begin errors++; $display("[TB] FAIL load_count[%0d]: got %0d expected %0d", i, load_count, i + 1); end
        end
        load_valid = 1'b0;
        load_done  = 1'b1;
        tick();
        load_done = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL load_done_state: got %0d expected 0", state); end
        checks++; if (mem_bus.i_write !== 1'b0) begin errors++; $display("[TB] FAIL load_done_i_write: got %b expected 0", mem_bus.i_write); end
        checks++; if (load_count !== 16'd3) begin errors++; $display("[TB] FAIL load_done_count: got %0d expected 3", load_count); end
    endtask

    task automatic test_run();
        start  = 1'b1;
        pc_mem = 32'd10000;
        tick();
        start = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL run_state: got %0d expected 2", state); end
        checks++; if (pc_init !== 1'b1) begin errors++; $display("[TB] FAIL run_pc_init: got %b expected 1", pc_init); end
        checks++; if (halt !== 1'b0) begin errors++; $display("[TB] FAIL run_halt: got %b expected 0", halt); end
        checks++; if (mem_bus.i_enable !== 1'b1) begin errors++; $display("[TB] FAIL run_i_enable: got %b expected 1", mem_bus.i_enable); end
        checks++; if (mem_bus.mem_addr !== 32'd10000) begin errors++; $display("[TB] FAIL run_addr0: got %0d expected 10000", mem_bus.mem_addr); end
        tick();
        checks++; if (pc_init !== 1'b0) begin errors++; $display("[TB] FAIL run_pc_init_pulse: got %b expected 0", pc_init); end
        pc_mem = 32'd10004;
        #1;
        checks++; if (mem_bus.mem_addr !== 32'd10004) begin errors++; $display("[TB] FAIL run_addr1: got %0d expected 10004", mem_bus.mem_addr); end
        pc_mem = 32'd10008;
        #1;
        checks++; if (mem_bus.mem_addr !== 32'd10008) begin errors++; $display("[TB] FAIL run_addr2: got %0d expected 10008", mem_bus.mem_addr); end
        checks++; if (mem_bus.i_write !== 1'b0) begin errors++; $display("[TB] FAIL run_i_write: got %b expected 0", mem_bus.i_write); end
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL run_stays: got %0d expected 2", state); end
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL halt_state: got %0d expected 3", state); end
        checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL halt_halt: got %b expected 1", halt); end
        checks++; if (mem_bus.i_enable !== 1'b0) begin errors++; $display("[TB] FAIL halt_i_enable: got %b expected 0", mem_bus.i_enable); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL halt_fault: got %b expected 0", fault); end
        tick();
        checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL halt_holds: got %0d expected 3", state); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL resume_state: got %0d expected 2", state); end
        checks++; if (halt !== 1'b0) begin errors++; $display("[TB] FAIL resume_halt: got %b expected 0", halt); end
        checks++; if (pc_init !== 1'b0) begin errors++; $display("[TB] FAIL resume_pc_init: got %b expected 0", pc_init); end
    endtask

    task automatic test_fault();
        pc_mem = 32'd10012;
        tick();
        checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL fault_end_state: got %0d expected 3", state); end
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_end_flag: got %b expected 1", fault); end
        checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL fault_end_halt: got %b expected 1", halt); end
        start  = 1'b1;
        pc_mem = 32'd10000;
        tick();
        start = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL fault_resume_state: got %0d expected 2", state); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL fault_resume_clear: got %b expected 0", fault); end
        pc_mem = 32'd10002;
        tick();
        checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL fault_align_state: got %0d expected 3", state); end
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_align_flag: got %b expected 1", fault); end
        start  = 1'b1;
        pc_mem = 32'd10004;
        tick();
        start  = 1'b0;
        pc_mem = 32'd9996;
        tick();
        checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL fault_low_state: got %0d expected 3", state); end
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_low_flag: got %b expected 1", fault); end
    endtask

    task automatic test_overflow();
        logic [31:0] words [5];
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        words[3] = 32'h44444444;
        words[4] = 32'h55555555;
        program_load = 1'b1;
        tick();
        program_load = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL ovf_enter_state: got %0d expected 1", state); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL ovf_enter_fault: got %b expected 0", fault); end
        checks++; if (load_count !== 16'd0) begin errors++; $display("[TB] FAIL ovf_enter_count: got %0d expected 0", load_count); end
        for (int i = 0; i < 4; i++) begin
            load_valid  = 1'b1;
            instruction = words[i];
            tick();
            checks++; if (mem_bus.i_write !== 1'b1) begin errors++; $display("[TB] FAIL ovf_i_write[%0d]: got %b expected 1", i, mem_bus.i_write); end
            checks++; if (mem_bus.mem_addr !== 32'd10000 + 32'(4 * i)) begin errors++; $display("[TB] FAIL ovf_addr[%0d]: got %0d expected %0d", i, mem_bus.mem_addr, 10000 + 4 * i); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early[%0d]: got %b expected 0", i, overflow); end
        end
        instruction = words[4];
        tick();
        load_valid = 1'b0;
        checks++; if (mem_bus.i_write !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drop_write: got %b expected 0", mem_bus.i_write); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (load_count !== 16'd4) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 4", load_count); end
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL ovf_done_state: got %0d expected 0", state); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
        program_load = 1'b1;
        start        = 1'b1;
        tick();
        program_load = 1'b0;
        start        = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL prio_state: got %0d expected 1", state); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL prio_overflow: got %b expected 0", overflow); end
        checks++; if (load_count !== 16'd0) begin errors++; $display("[TB] FAIL prio_count: got %0d expected 0", load_count); end
    endtask

    task automatic test_done_with_word();
        load_valid  = 1'b1;
        instruction = 32'hCAFE0001;
        load_done   = 1'b1;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL dw_state: got %0d expected 0", state); end
        checks++; if (mem_bus.i_write !== 1'b1) begin errors++; $display("[TB] FAIL dw_i_write: got %b expected 1", mem_bus.i_write); end
        checks++; if (mem_bus.mem_addr !== 32'd10000) begin errors++; $display("[TB] FAIL dw_addr: got %0d expected 10000", mem_bus.mem_addr); end
        checks++; if (mem_bus.mem_wdata !== 32'hCAFE0001) begin errors++; $display("[TB] FAIL dw_wdata: got %h expected cafe0001", mem_bus.mem_wdata); end
        checks++; if (load_count !== 16'd1) begin errors++; $display("[TB] FAIL dw_count: got %0d expected 1", load_count); end
        tick();
        checks++; if (mem_bus.i_write !== 1'b0) begin errors++; $display("[TB] FAIL dw_idle_write: got %b expected 0", mem_bus.i_write); end
    endtask

    task automatic test_reset_mid_load();
        program_load = 1'b1;
        tick();
        program_load = 1'b0;
        load_valid   = 1'b1;
        instruction  = 32'hDEADBEEF;
        tick();
        checks++; if (load_count !== 16'd1) begin errors++; $display("[TB] FAIL mid_pre_count: got %0d expected 1", load_count); end
        reset = 1'b1;
        tick();
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL mid_reset_state: got %0d expected 0", state); end
        checks++; if (load_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", load_count); end
        checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_halt: got %b expected 1", halt); end
        checks++; if (mem_bus.i_write !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_i_write: got %b expected 0", mem_bus.i_write); end
        reset      = 1'b0;
        load_valid = 1'b0;
    endtask

    // Main sequence: each task leaves the DUT in the state the next expects.
    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        program_load = 1'b0;
        start        = 1'b0;
        load_valid   = 1'b0;
        instruction  = 32'd0;
        load_done    = 1'b0;
        halt_req     = 1'b0;
        pc_mem       = 32'd0;
        test_reset();
        test_start_ignored_when_empty();
        test_load();
        test_run();
        test_halt();
        test_fault();
        test_overflow();
        test_done_with_word();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_controller.md
Name: imem_controller

Overview:
- Sequencer and arbiter for the instruction-fetch stage and its instruction memory port.
- Owns the single memory port. In load mode it writes a program word by word; in run mode it hands the port to the fetch address (pc_mem) and releases halt.
- Sits between the top-level control inputs (program_load, start, halt requests) and if_stage, and drives if_stage's halt and the memory's i_write/i_enable.

Parameters:
- LOAD_BASE, 32'd10000, byte address of program word 0.
- MAX_WORDS, 1024, load capacity in words.
- CNT_W, 16, width of load_count (must hold MAX_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- program_load  in  1  request to enter LOAD.
- start  in  1  request to enter RUN.
- load_valid  in  1  instruction holds a program word this cycle.
- instruction  in  32  program word to load.
- load_done  in  1  end of program image.
- halt_req  in  1  halt request from decode (halt/syscall).
- pc_mem  in  32  fetch byte address from if_stage.
- halt  out  1  freezes if_stage PC.
- i_write  out  1  instruction-memory write strobe.
- i_enable  out  1  instruction-memory enable.
- mem_addr  out  32  instruction-memory byte address.
- mem_wdata  out  32  instruction-memory write data.
- pc_init  out  1  one-cycle pulse; if_stage loads npc = LOAD_BASE.
- load_count  out  CNT_W  words loaded.
- overflow  out  1  sticky: load word dropped because the memory was full.
- fault  out  1  sticky: fetch went outside the loaded image.
- state  out  2  IDLE=0, LOAD=1, RUN=2, HALTED=3.

Behaviour:
- Reset values (on the edge where reset=1): state=IDLE, halt=1, i_write=0, i_enable=0, mem_addr=0, mem_wdata=0, pc_init=0, load_count=0, overflow=0, fault=0.
  - Reset has priority over all inputs, including mid-LOAD and mid-RUN.
- Outputs are registered, except mem_addr in RUN, which equals pc_mem combinationally (zero-latency fetch path).
- IDLE:
  - halt=1, i_enable=0.
  - program_load → LOAD. On entry: load_count=0, overflow=0, fault=0.
  - start with load_count≠0 → RUN, with pc_init=1 for exactly the first RUN cycle.
  - start with load_count=0 is ignored.
  - program_load and start together: program_load wins.
- LOAD:
  - halt=1.
  - When load_valid=1 and load_count<MAX_WORDS, on the next cycle: i_write=1, i_enable=1, mem_addr=LOAD_BASE+4*load_count (old value), mem_wdata=instruction. load_count then increments. Write latency is 1 cycle.
  - With no accepted word: i_write=0, i_enable=0.
  - load_valid with load_count=MAX_WORDS: word dropped, no write, overflow=1.
  - load_done → IDLE. A word presented in the same cycle as load_done is still written, in the first IDLE cycle.
  - start is ignored in LOAD.
- RUN:
  - halt=0, i_enable=1, i_write=0, mem_addr=pc_mem.
  - halt_req → HALTED; halt=1 from the next cycle.
  - pc_mem < LOAD_BASE, or pc_mem ≥ LOAD_BASE+4*load_count, or pc_mem[1:0]≠0 (evaluated while pc_init=0) → HALTED with fault=1.
  - halt_req and a fault in the same cycle: both take effect.
  - program_load and start are ignored in RUN.
- HALTED:
  - halt=1, i_enable=0, PC contents preserved in if_stage.
  - start → RUN (resume, no pc_init; fault cleared).
  - program_load → LOAD. If both, program_load wins.
- Address arithmetic is 32-bit unsigned. load_count is zero-extended and shifted left by 2.
- The FSM is the only writer of state. No transition other than those listed.

Test Plan:
- Reset held 2 cycles in any state → state=0, halt=1, i_write=0, load_count=0, overflow=0, fault=0.
- program_load, then 3 words 0x20080005, 0x20090007, 0x01095020 on consecutive cycles, then load_done → writes at mem_addr 10000/10004/10008 one cycle after each word; load_count=3; state=IDLE.
- start after that load → pc_init=1 for one cycle, halt=0. Drive pc_mem=10000,10004,10008 → mem_addr follows with zero latency, i_write=0.
- halt_req in RUN → halt=1 next cycle, state=3. Then start → RUN, halt=0, pc_init=0.
- pc_mem=10012 with load_count=3 → fault=1, state=HALTED. pc_mem=10002 gives the same response.
- MAX_WORDS=4; load 5 words → 4 writes (10000..10012), 5th dropped, overflow=1. Then program_load and start in the same cycle → state=LOAD, overflow=0. Reset asserted mid-LOAD → load_count=0.
